// File: rtl/riscv_pkg.sv
// Shared core constants.
//   XLEN_DEFAULT : default address/PC width
//   ILEN         : instruction word width
//   NOP          : canonical NOP encoding (addi x0, x0, 0)
//   PC_INC       : PC step between sequential instructions
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned ILEN         = 32;
    localparam logic [ILEN-1:0] NOP      = 32'h0000_0013;
    localparam int unsigned PC_INC       = 4;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous FIFO for the fetch unit's prefetch buffer.
//   clk, resetn : clock, asynchronous active-low reset
//   clear_i     : synchronous flush; wins over push_i and pop_i
//   push_i      : write data_i (ignored when full)
//   pop_i       : drop head entry (ignored when empty)
//   data_o      : head entry; content is undefined while empty
//   count_o     : number of stored entries
//   empty_o     : no entries
//   full_o      : DEPTH entries
// DEPTH must be a power of two so the pointers wrap naturally.
module riscv_fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: it is only observed through a valid count.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Decoupled instruction-fetch front end.
//   clk, resetn        : clock, asynchronous active-low reset
//   imem_req_*_o/_i    : valid/ready fetch request, word-aligned address
//   imem_rsp_*_i       : in-order response beats, no backpressure
//   redirect_*_i       : taken branch/jump from EX; flushes and restarts fetch
//   out_*_o / out_ready_i : instruction stream to decode
// Holds the PCs, outstanding/drop counters and handshake control; instructions
// are buffered in riscv_fetch_fifo.
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN       = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            resetn,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [ILEN-1:0] imem_rsp_data_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [ILEN-1:0] out_instr_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENT_W = XLEN + ILEN;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic             fifo_clear, fifo_push, fifo_pop;
    logic [ENT_W-1:0] fifo_rdata;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty, fifo_full;

    logic             req_fire, rsp_ok;
    logic [CNT_W:0]   in_use;
    logic [XLEN-1:0]  redirect_aligned;

    assign redirect_aligned = {redirect_pc_i[XLEN-1:2], 2'b00};

    // A response with nothing outstanding is a protocol error (or a stale beat
    // from before reset) and is ignored entirely.
    assign rsp_ok = imem_rsp_valid_i && (outst_q != '0);

    assign out_valid_o = !fifo_empty && !redirect_valid_i;
    assign fifo_pop    = out_valid_o && out_ready_i;
    assign out_pc_o    = fifo_empty ? '0  : fifo_rdata[ENT_W-1 -: XLEN];
    assign out_instr_o = fifo_empty ? NOP : fifo_rdata[ILEN-1:0];

    // Credit: every buffered or in-flight instruction owns a FIFO slot, so a
    // push can never overflow. A slot being popped this cycle is already free,
    // which keeps a zero-wait memory at one instruction per cycle.
    assign in_use = {1'b0, fifo_count} + {1'b0, outst_q} - {{CNT_W{1'b0}}, fifo_pop};

    // Gating with resetn keeps the request low while reset is held.
    assign imem_req_valid_o = resetn && !redirect_valid_i &&
                              (in_use < (CNT_W + 1)'(FIFO_DEPTH));
    assign imem_req_addr_o  = fetch_pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        fifo_clear = 1'b0;
        fifo_push  = 1'b0;
        outst_d    = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_ok);

        if (redirect_valid_i) begin
            // Everything still in flight belongs to the old path; a beat
            // arriving now is dropped here, so it is not counted again.
            fifo_clear = 1'b1;
            fetch_pc_d = redirect_aligned;
            rsp_pc_d   = redirect_aligned;
            drop_d     = outst_q - CNT_W'(rsp_ok);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
            if (rsp_ok) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_W'(1);
                end else begin
                    fifo_push = !fifo_full;
                    rsp_pc_d  = rsp_pc_q + XLEN'(PC_INC);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    riscv_fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .clear_i (fifo_clear),
        .push_i  (fifo_push),
        .data_i  ({rsp_pc_q, imem_rsp_data_i}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit (RESET_PC 0x100, FIFO_DEPTH 2).
// A queue-based memory answers in order after a per-request wait; a scoreboard
// expects the sequential PC stream, restarting at each redirect target.
module tb_riscv_fetch_unit;

    localparam int unsigned    XLEN  = 32;
    localparam int unsigned    DEPTH = 2;
    localparam logic [31:0]    RPC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    always #5 clk = ~clk;

    riscv_fetch_unit #(
        .XLEN       (XLEN),
        .RESET_PC   (RPC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .imem_req_valid_o (imem_req_valid),
        .imem_req_ready_i (imem_req_ready),
        .imem_req_addr_o  (imem_req_addr),
        .imem_rsp_valid_i (imem_rsp_valid),
        .imem_rsp_data_i  (imem_rsp_data),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_pc_o         (out_pc),
        .out_instr_o      (out_instr)
    );

    typedef struct {
        logic [31:0] addr;
        longint      due;
    } mreq_t;

    typedef struct {
        logic        ordy;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_out_valid;
        logic [31:0] exp_out_pc;
    } vec_t;

    mreq_t       mq[$];
    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    logic [31:0] exp_pc;
    int          delivered = 0;
    logic [31:0] first_pc = '0;
    bit          first_seen = 0;
    int          max_out = 0;
    logic        s_req_valid, s_out_valid;
    logic [31:0] s_req_addr, s_out_pc;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
    endfunction

    function automatic bit rsp_due();
        return (mq.size() > 0) && (mq[0].due <= cyc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at posedge+1, sample/score at negedge.
    task automatic cycle(input bit rdy, input bit ordy, input bit redir,
                         input logic [31:0] rpc, input int unsigned wt);
        mreq_t e;
        imem_req_ready = rdy;
        out_ready      = ordy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (rsp_due()) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        if (redir) begin
            chk("redir_out_valid", {31'd0, out_valid}, 32'd0);
            chk("redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
            exp_pc     = rpc & 32'hFFFF_FFFC;
            first_seen = 0;
        end else if (out_valid && out_ready) begin
            chk("out_pc", out_pc, exp_pc);
            chk("out_instr", out_instr, mem_data(exp_pc));
            if (!first_seen) first_pc = out_pc;
            first_seen = 1;
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        if (imem_rsp_valid) void'(mq.pop_front());
        if (imem_req_valid && rdy) begin
            e.addr = imem_req_addr;
            e.due  = cyc + 1 + longint'(wt);
            mq.push_back(e);
        end
        if (mq.size() > max_out) max_out = mq.size();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int   d0;
        int   n;
        bit   saw_low;

        // Zero-wait memory, decode always ready: one request and, two cycles
        // later, one instruction per cycle.
        vecs[0] = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
        vecs[3] = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
        vecs[4] = '{1'b1, 1'b1, 32'h110, 1'b1, 32'h108};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'h0000_0013);

        exp_pc = RPC;
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, vecs[i].ordy, 1'b0, 32'd0, 0);
            chk("vec_req_valid", {31'd0, s_req_valid}, {31'd0, vecs[i].exp_req_valid});
            chk("vec_req_addr", s_req_addr, vecs[i].exp_req_addr);
            chk("vec_out_valid", {31'd0, s_out_valid}, {31'd0, vecs[i].exp_out_valid});
            chk("vec_out_pc", s_out_pc, vecs[i].exp_out_pc);
        end

        // Decode stalls: FIFO fills, requests stop, then drain at full rate.
        repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'd0, 0);
        chk("stall_req_valid", {31'd0, s_req_valid}, 32'd0);
        chk("stall_out_valid", {31'd0, s_out_valid}, 32'd1);
        chk("stall_head_pc", s_out_pc, exp_pc);
        chk("stall_in_flight", mq.size(), 32'd0);
        d0 = delivered;
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'd0, 0);
        chk("drain_rate", delivered - d0, 32'd10);

        // Three wait states: credit caps outstanding at FIFO_DEPTH.
        max_out = 0;
        saw_low = 0;
        d0 = delivered;
        repeat (40) begin
            cycle(1'b1, 1'b1, 1'b0, 32'd0, 3);
            if (!s_req_valid) saw_low = 1;
        end
        chk("ws_max_outstanding", max_out, 32'd2);
        chk("ws_req_throttled", {31'd0, saw_low}, 32'd1);
        chk("ws_progress", {31'd0, delivered > d0}, 32'd1);

        // Redirect with two requests in flight.
        n = 0;
        while (mq.size() != 2 && n < 20) begin
            cycle(1'b1, 1'b1, 1'b0, 32'd0, 3);
            n++;
        end
        chk("redir_two_in_flight", mq.size(), 32'd2);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_2002, 3);
        n = 0;
        do begin
            cycle(1'b1, 1'b1, 1'b0, 32'd0, 3);
            n++;
        end while (!s_req_valid && n < 20);
        chk("redir_next_req_valid", {31'd0, s_req_valid}, 32'd1);
        chk("redir_next_req_addr", s_req_addr, 32'h0000_2000);
        repeat (20) cycle(1'b1, 1'b1, 1'b0, 32'd0, 3);
        chk("redir_first_seen", {31'd0, first_seen}, 32'd1);
        chk("redir_first_pc", first_pc, 32'h0000_2000);

        // Redirect on a response beat, then a second redirect next cycle.
        repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1);
        n = 0;
        while (!rsp_due() && n < 20) begin
            cycle(1'b1, 1'b1, 1'b0, 32'd0, 1);
            n++;
        end
        chk("dbl_rsp_at_redirect", {31'd0, rsp_due()}, 32'd1);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_1004, 1);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_3000, 1);
        repeat (25) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1);
        chk("dbl_first_seen", {31'd0, first_seen}, 32'd1);
        chk("dbl_first_pc", first_pc, 32'h0000_3000);

        // Reset with two requests outstanding; stale beats follow release.
        n = 0;
        while (mq.size() != 2 && n < 20) begin
            cycle(1'b1, 1'b1, 1'b0, 32'd0, 3);
            n++;
        end
        chk("mrst_two_in_flight", mq.size(), 32'd2);
        resetn = 1'b0;
        #1;
        chk("mrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("mrst_req_addr", imem_req_addr, RPC);
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_out_pc", out_pc, 32'd0);
        chk("mrst_out_instr", out_instr, 32'h0000_0013);
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        foreach (mq[i]) mq[i].due = 0;
        exp_pc     = RPC;
        first_seen = 0;
        resetn     = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 0);
        chk("mrst_restart_valid", {31'd0, s_req_valid}, 32'd1);
        chk("mrst_restart_addr", s_req_addr, RPC);
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 0);
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 0);
        chk("mrst_stale_drained", mq.size(), 32'd0);
        chk("mrst_stale_ignored", {31'd0, s_out_valid}, 32'd0);
        repeat (20) cycle(1'b1, 1'b1, 1'b0, 32'd0, 0);
        chk("mrst_first_pc", first_pc, RPC);

        // Randomized traffic against the scoreboard.
        max_out = 0;
        d0 = delivered;
        repeat (600) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3));
        end
        chk("rnd_credit_bound", {31'd0, max_out <= 2}, 32'd1);
        chk("rnd_progress", {31'd0, (delivered - d0) >= 60}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_unit.md
# riscv_fetch_unit

Parametrised instruction-fetch front end for the pipelined RISC-V core. It replaces the single-register PC/IF-ID path with a decoupled fetcher that has a valid/ready IMEM request port, in-order responses with wait states, and a prefetch FIFO of configurable depth. It also supports branch/jump redirect that flushes the FIFO and discards in-flight responses. It sits between the instruction memory and the decode stage.

## Interface
- XLEN, 32, address/PC width (32 or 64)
- RESET_PC, 0, first fetch address after reset
- FIFO_DEPTH, 2, prefetch entries; power of two, ≥2; also the bound on outstanding requests
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  response beat; in order, no backpressure, earliest one cycle after acceptance
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  branch/jump taken from EX
- redirect_pc  in  XLEN  new PC; bits [1:0] ignored, forced to 0
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts (low = stall)
- out_pc  out  XLEN  PC of out_instr
- out_instr  out  32  instruction word

## Operation
- State: fetch_pc (next request address), rsp_pc (PC of next expected non-dropped response), outstanding (accepted requests not yet answered), drop_cnt (responses still to discard), FIFO of {pc, instr}.
- imem_req_valid = !redirect_valid && (fifo_count + outstanding < FIFO_DEPTH); imem_req_addr = fetch_pc.
- Request handshake (valid && ready): fetch_pc += 4 (mod 2^XLEN, wraps), outstanding += 1.
- Response with drop_cnt > 0: data discarded, drop_cnt -= 1, outstanding -= 1.
- Response with drop_cnt == 0: push {rsp_pc, rsp_data}, rsp_pc += 4, outstanding -= 1.
- Same-cycle request and response: outstanding unchanged.
- out_valid = FIFO not empty && !redirect_valid; pop on out_valid && out_ready.
- Redirect cycle: FIFO cleared; no pop; no request issued. fetch_pc ← rsp_pc ← {redirect_pc[XLEN-1:2],2'b00}. drop_cnt ← outstanding − (imem_rsp_valid ? 1 : 0), with any response in that cycle also discarded.
- Back-to-back redirects: the last one wins. Every cycle recomputes drop_cnt from the current outstanding count.
- Redirect may withdraw a pending unaccepted request. IMEM must tolerate valid dropping without ready.
- The credit rule guarantees a FIFO push never overflows. A response with outstanding == 0 is a protocol error and is ignored.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, out_valid 0, out_pc 0, out_instr 0x00000013 (NOP). fetch_pc = rsp_pc = RESET_PC; counters and FIFO empty.
- First cycle after reset release: imem_req_valid = 1, addr RESET_PC.
- Latency: a response in cycle N appears on out_* in cycle N+1. No response-to-output bypass.
- Steady state with a zero-wait memory, always-ready decode and FIFO_DEPTH ≥ 2: one instruction per cycle.
- First new-path request: the cycle after redirect. First new-path out_valid: 2 cycles after that request's acceptance, plus memory wait states.
- Reset asserted mid-operation clears all state immediately. Responses arriving after reset release with outstanding == 0 are ignored.

## Structure
- Shared package riscv_pkg holds XLEN default, ILEN = 32, the NOP encoding 32'h00000013 and the PC increment constant. Core and fetch unit import it.
- One sub-module: riscv_fetch_fifo. It is a synchronous FIFO (WIDTH = XLEN + 32, DEPTH = FIFO_DEPTH) with push, pop, synchronous clear, count, empty and full. Clear has priority over push and pop.
- The top-level logic holds only PC, counters and handshake control.

## Test plan
- Reset, RESET_PC = 0x100, zero-wait memory, out_ready = 1 → addresses 0x100, 0x104, 0x108 on consecutive cycles. out_pc follows one cycle after each response, one instruction per cycle.
- Memory with 3 wait cycles per response, FIFO_DEPTH = 2 → never more than 2 outstanding, imem_req_valid drops at credit limit, all PCs delivered in order with no gaps.
- out_ready held low 10 cycles → FIFO fills to 2 and requests stop. On release, the 2 entries drain in order and fetch resumes at the correct PC.
- Redirect to 0x2002 with 2 requests in flight → both responses discarded, next request 0x2000, first out_pc = 0x2000.
- Redirect coinciding with a response and a pending request → response dropped, no request issued that cycle, drop_cnt = outstanding − 1. Followed by a second redirect the next cycle → only the second target is fetched.
- resetn pulsed low while 2 requests outstanding → outputs return to reset values at once. Stale responses after release are ignored, and fetch restarts at RESET_PC.
